rlwe_instr_loader: RTL and testbench
====================================

Name: rlwe_instr_loader

Overview:
Producer end of the instruction FIFO that feeds the RLWE core's instruction memory. Receives a framed little-endian byte stream from the host link (valid/ready) and assembles 32-bit instruction words. Enqueues each word into the FIFO while honouring full, and checks a frame length and checksum. Reports load status to host control logic.

Parameters:
WIDTH, 32, FIFO word width (fixed 4 bytes per word; other values unsupported)
MAX_WORDS, 262144, max payload words per frame (1 MiB / 4)
CNT_W, $clog2(MAX_WORDS+1), width of word counters

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  host byte valid
in_ready  output  1  loader accepts byte this cycle
in_data  input  8  host byte
clear  input  1  sync pulse: abort/return to LEN state
full  input  1  FIFO full
enqueue_en  output  1  FIFO write strobe (one word per cycle high)
value_i  output  WIDTH  FIFO write data
busy  output  1  frame in progress (state DATA or CHK)
done  output  1  frame finished, sticky until clear/reset
err_len  output  1  illegal length, sticky until clear/reset
err_chk  output  1  checksum mismatch, valid with done
words_loaded  output  CNT_W  words enqueued in current frame

Behaviour:
- Frame format: LEN (4 bytes, word count N, LE), payload (4N bytes, LE words), CHK (4 bytes, LE, = sum of payload words mod 2^32).
- Byte handshake: a byte is accepted when in_valid && in_ready at posedge. byte_cnt (2 bits) selects the lane, so the first byte goes to [7:0]. It wraps 3->0 on each completed word.
- States: LEN, DATA, CHK, DONE, ERR. Reset state is LEN.
- LEN: in_ready=1. After the 4th byte:
  - N==0 or N>MAX_WORDS -> ERR, err_len=1.
  - Otherwise -> DATA, words_loaded=0, sum=0.
- DATA: in_ready = !pending.
  - The 4th byte of a word loads value_i and sets pending=1 on the next edge.
  - enqueue_en = pending && !full && !clear (combinational). On an enqueue edge: pending<=0, words_loaded+1, sum+=value_i.
  - Latency: 4th byte accepted at edge t -> enqueue_en high in cycle after t if !full. Throughput is 1 word per 5 cycles minimum.
  - full holds pending, in_ready and value_i stable. No word is dropped or duplicated.
  - When the enqueue of word N occurs -> CHK.
- CHK: in_ready=1. After the 4th byte -> DONE. err_chk = (received != sum). done=1.
- DONE and ERR: in_ready=0, enqueue_en=0. Both remain until clear.
- clear (any state): -> LEN next edge. Takes priority over a same-cycle byte and enqueue.
  - Clears byte_cnt, pending, sum, words_loaded, done, err_len, err_chk.
  - Words already enqueued stay in the FIFO.
- Reset values: in_ready=1 (state LEN), enqueue_en=0, value_i=0, busy=0, done=0, err_len=0, err_chk=0, words_loaded=0, pending=0.
- Reset mid-frame has the same effect as clear; the partial word is discarded.
- Checksum arithmetic wraps mod 2^32. Counters never exceed MAX_WORDS.

Test Plan:
- Normal frame: bytes 02 00 00 00 | 13 00 00 00 | 93 00 10 00 | A6 00 10 00 -> enqueue 0x00000013 then 0x00100093, words_loaded=2, done=1, err_chk=0.
- Backpressure: same frame with full=1 for 10 cycles after the first word is assembled -> enqueue_en=0 and in_ready=0 throughout; value_i is held at 0x00000013; exactly 2 enqueues in total.
- Bad checksum: checksum bytes A7 00 10 00 -> 2 words enqueued, done=1, err_chk=1.
- Length 0 (00 00 00 00) and length 0x00040001 -> ERR, err_len=1, no enqueue, in_ready=0 until clear.
- clear pulsed after 6 payload bytes of a 2-word frame -> 1 word enqueued, state LEN, all status 0. A following valid frame loads correctly.
- rst_n asserted asynchronously mid-word with pending=1 and full=1 -> all outputs immediately at reset values, no enqueue after release.

Source files
------------

// File: rtl/rlwe_instr_loader_if.sv
// rlwe_instr_loader_if: host byte stream, FIFO write port and load status bundle
interface rlwe_instr_loader_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 19
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             clear;
  logic             full;
  logic             enqueue_en;
  logic [WIDTH-1:0] value_i;
  logic             busy;
  logic             done;
  logic             err_len;
  logic             err_chk;
  logic [CNT_W-1:0] words_loaded;
  modport master (
    output in_valid, in_data, clear, full,
    input  in_ready, enqueue_en, value_i, busy, done, err_len, err_chk, words_loaded
  );
  modport slave (
    input  in_valid, in_data, clear, full,
    output in_ready, enqueue_en, value_i, busy, done, err_len, err_chk, words_loaded
  );
endinterface

// File: rtl/rlwe_instr_loader.sv
// rlwe_instr_loader: assembles framed LE byte stream into 32-bit words and enqueues them into the instruction FIFO
module rlwe_instr_loader #(
  parameter int WIDTH     = 32,
  parameter int MAX_WORDS = 262144,
  parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input logic              clk,
  input logic              rst_n,
  rlwe_instr_loader_if.slave bus
);
  typedef enum logic [2:0] {S_LEN, S_DATA, S_CHK, S_DONE, S_ERR} state_e;
  state_e           state_q, state_d;
  logic [1:0]       byte_q, byte_d;
  logic [23:0]      asm_q, asm_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             done_q, done_d;
  logic             err_len_q, err_len_d;
  logic             err_chk_q, err_chk_d;
  logic             in_rdy;
  logic             acc;
  logic             last;
  logic             enq;
  logic [WIDTH-1:0] word;
  // handshake decode; the first three bytes shift down so the fourth lands on top
  always_comb begin
    in_rdy = (state_q == S_LEN) || (state_q == S_CHK) || (state_q == S_DATA && !pend_q);
    acc    = bus.in_valid && in_rdy;
    last   = acc && (byte_q == 2'd3);
    enq    = (state_q == S_DATA) && pend_q && !bus.full && !bus.clear;
    word   = {bus.in_data, asm_q};
  end
  // next-state and datapath updates; clear overrides everything else
  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    asm_d     = asm_q;
    pend_d    = pend_q;
    value_d   = value_q;
    sum_d     = sum_q;
    words_d   = words_q;
    len_d     = len_q;
    done_d    = done_q;
    err_len_d = err_len_q;
    err_chk_d = err_chk_q;
    if (acc) begin
      byte_d = byte_q + 2'd1;
      asm_d  = {bus.in_data, asm_q[23:8]};
    end
    case (state_q)
      S_LEN: begin
        if (last) begin
          if (word == '0 || word > WIDTH'(MAX_WORDS)) begin
            state_d   = S_ERR;
            err_len_d = 1'b1;
          end else begin
            state_d = S_DATA;
            len_d   = word[CNT_W-1:0];
            words_d = '0;
            sum_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (last) begin
          value_d = word;
          pend_d  = 1'b1;
        end
        if (enq) begin
          pend_d  = 1'b0;
          words_d = words_q + CNT_W'(1);
          sum_d   = sum_q + value_q;
          state_d = (words_q + CNT_W'(1) == len_q) ? S_CHK : S_DATA;
        end
      end
      S_CHK: begin
        if (last) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          err_chk_d = (word != sum_q);
        end
      end
      default: ;
    endcase
    if (bus.clear) begin
      state_d   = S_LEN;
      byte_d    = '0;
      pend_d    = 1'b0;
      sum_d     = '0;
      words_d   = '0;
      done_d    = 1'b0;
      err_len_d = 1'b0;
      err_chk_d = 1'b0;
    end
  end
  // state registers; reset drops any partial word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_LEN;
      byte_q    <= '0;
      asm_q     <= '0;
      pend_q    <= 1'b0;
      value_q   <= '0;
      sum_q     <= '0;
      words_q   <= '0;
      len_q     <= '0;
      done_q    <= 1'b0;
      err_len_q <= 1'b0;
      err_chk_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      asm_q     <= asm_d;
      pend_q    <= pend_d;
      value_q   <= value_d;
      sum_q     <= sum_d;
      words_q   <= words_d;
      len_q     <= len_d;
      done_q    <= done_d;
      err_len_q <= err_len_d;
      err_chk_q <= err_chk_d;
    end
  end
  assign bus.in_ready     = in_rdy;
  assign bus.enqueue_en   = enq;
  assign bus.value_i      = value_q;
  assign bus.busy         = (state_q == S_DATA) || (state_q == S_CHK);
  assign bus.done         = done_q;
  assign bus.err_len      = err_len_q;
  assign bus.err_chk      = err_chk_q;
  assign bus.words_loaded = words_q;
endmodule

// File: tb/tb_rlwe_instr_loader.sv
// tb_rlwe_instr_loader: directed frame vectors against hand-computed FIFO writes and status
module tb_rlwe_instr_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  int enq_cnt = 0;
  logic [31:0] enq_log [0:63];
  rlwe_instr_loader_if #(.WIDTH(32), .CNT_W(19)) bus ();
  rlwe_instr_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rst_n && bus.enqueue_en) begin
      enq_log[enq_cnt[5:0]] <= bus.value_i;
      enq_cnt <= enq_cnt + 1;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("ready_timeout", 32'(t), 32'd0);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask
  task automatic pulse_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int base;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.clear    = 1'b0;
    bus.full     = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_enq", 32'(bus.enqueue_en), 32'd0);
    check("rst_value", bus.value_i, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err_len", 32'(bus.err_len), 32'd0);
    check("rst_err_chk", 32'(bus.err_chk), 32'd0);
    check("rst_words", 32'(bus.words_loaded), 32'd0);
    // normal frame
    base = enq_cnt;
    send_word(32'd2);
    check("len_busy", 32'(bus.busy), 32'd1);
    send_word(32'h0000_0013);
    check("lat_enq", 32'(bus.enqueue_en), 32'd1);
    check("lat_value", bus.value_i, 32'h0000_0013);
    send_word(32'h0010_0093);
    send_word(32'h0010_00A6);
    idle(2);
    check("n_enq", 32'(enq_cnt - base), 32'd2);
    check("n_w0", enq_log[base], 32'h0000_0013);
    check("n_w1", enq_log[base + 1], 32'h0010_0093);
    check("n_words", 32'(bus.words_loaded), 32'd2);
    check("n_done", 32'(bus.done), 32'd1);
    check("n_err_chk", 32'(bus.err_chk), 32'd0);
    check("n_busy", 32'(bus.busy), 32'd0);
    check("n_ready", 32'(bus.in_ready), 32'd0);
    pulse_clear();
    check("clr_done", 32'(bus.done), 32'd0);
    check("clr_words", 32'(bus.words_loaded), 32'd0);
    check("clr_ready", 32'(bus.in_ready), 32'd1);
    // backpressure on the first word
    base = enq_cnt;
    bus.full = 1'b1;
    send_word(32'd2);
    send_word(32'h0000_0013);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_enq", 32'(bus.enqueue_en), 32'd0);
      check("bp_ready", 32'(bus.in_ready), 32'd0);
      check("bp_value", bus.value_i, 32'h0000_0013);
    end
    bus.full = 1'b0;
    send_word(32'h0010_0093);
    send_word(32'h0010_00A6);
    idle(2);
    check("bp_n_enq", 32'(enq_cnt - base), 32'd2);
    check("bp_w0", enq_log[base], 32'h0000_0013);
    check("bp_w1", enq_log[base + 1], 32'h0010_0093);
    check("bp_done", 32'(bus.done), 32'd1);
    check("bp_err_chk", 32'(bus.err_chk), 32'd0);
    pulse_clear();
    // bad checksum
    base = enq_cnt;
    send_word(32'd2);
    send_word(32'h0000_0013);
    send_word(32'h0010_0093);
    send_word(32'h0010_00A7);
    idle(2);
    check("bc_n_enq", 32'(enq_cnt - base), 32'd2);
    check("bc_done", 32'(bus.done), 32'd1);
    check("bc_err_chk", 32'(bus.err_chk), 32'd1);
    pulse_clear();
    check("bc_clr_err_chk", 32'(bus.err_chk), 32'd0);
    // zero length
    base = enq_cnt;
    send_word(32'd0);
    idle(3);
    check("l0_err_len", 32'(bus.err_len), 32'd1);
    check("l0_ready", 32'(bus.in_ready), 32'd0);
    check("l0_busy", 32'(bus.busy), 32'd0);
    check("l0_n_enq", 32'(enq_cnt - base), 32'd0);
    pulse_clear();
    check("l0_clr", 32'(bus.err_len), 32'd0);
    // one past the largest legal length
    send_word(32'h0004_0001);
    idle(3);
    check("lmax1_err_len", 32'(bus.err_len), 32'd1);
    check("lmax1_ready", 32'(bus.in_ready), 32'd0);
    check("lmax1_n_enq", 32'(enq_cnt - base), 32'd0);
    pulse_clear();
    // largest legal length is accepted
    send_word(32'h0004_0000);
    idle(1);
    check("lmax_err_len", 32'(bus.err_len), 32'd0);
    check("lmax_busy", 32'(bus.busy), 32'd1);
    pulse_clear();
    check("lmax_clr_busy", 32'(bus.busy), 32'd0);
    // clear after six payload bytes
    base = enq_cnt;
    send_word(32'd2);
    send_word(32'h0000_0013);
    send_byte(8'h93);
    send_byte(8'h00);
    check("ab_words", 32'(bus.words_loaded), 32'd1);
    pulse_clear();
    check("ab_n_enq", 32'(enq_cnt - base), 32'd1);
    check("ab_ready", 32'(bus.in_ready), 32'd1);
    check("ab_busy", 32'(bus.busy), 32'd0);
    check("ab_words_clr", 32'(bus.words_loaded), 32'd0);
    check("ab_done", 32'(bus.done), 32'd0);
    base = enq_cnt;
    send_word(32'd2);
    send_word(32'h0000_0013);
    send_word(32'h0010_0093);
    send_word(32'h0010_00A6);
    idle(2);
    check("ab2_n_enq", 32'(enq_cnt - base), 32'd2);
    check("ab2_w0", enq_log[base], 32'h0000_0013);
    check("ab2_w1", enq_log[base + 1], 32'h0010_0093);
    check("ab2_done", 32'(bus.done), 32'd1);
    check("ab2_err_chk", 32'(bus.err_chk), 32'd0);
    pulse_clear();
    // asynchronous reset with a word pending behind full
    base = enq_cnt;
    bus.full = 1'b1;
    send_word(32'd1);
    send_word(32'hDEAD_BEEF);
    idle(1);
    check("ar_pend_value", bus.value_i, 32'hDEAD_BEEF);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("ar_ready", 32'(bus.in_ready), 32'd1);
    check("ar_enq", 32'(bus.enqueue_en), 32'd0);
    check("ar_value", bus.value_i, 32'd0);
    check("ar_busy", 32'(bus.busy), 32'd0);
    check("ar_words", 32'(bus.words_loaded), 32'd0);
    @(negedge clk);
    bus.full = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(5);
    check("ar_n_enq", 32'(enq_cnt - base), 32'd0);
    check("ar_enq_after", 32'(bus.enqueue_en), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
